// File: rtl/me_pkg.sv
// Shared constants, row/word types and FSM states for the motion-estimation block feeder.
package me_pkg;

    localparam int BLK_ROWS = 16;
    localparam int ROW_PIX  = 8;
    localparam int PIX_W    = 8;
    localparam int RANGE    = 16;
    localparam int WIN_ROWS = BLK_ROWS + RANGE - 1;
    localparam int WIN_PIX  = ROW_PIX + RANGE - 1;

    localparam int ROW_W   = ROW_PIX * PIX_W;
    localparam int WIN_W   = WIN_PIX * PIX_W;
    localparam int FRAME_W = BLK_ROWS * ROW_W;
    localparam int N_CAND  = RANGE * RANGE;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [WIN_W-1:0] win_row_t;
    typedef logic [3:0]       mv_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CUR,
        ST_LOAD_WIN,
        ST_SCAN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/me_win_slice.sv
// Combinational extractor: picks the 16 displaced 64-bit rows of the search window
// addressed by a candidate motion vector.
module me_win_slice
    import me_pkg::*;
(
    input  win_row_t           win_i [WIN_ROWS],
    input  mv_t                mv_x_i,
    input  mv_t                mv_y_i,
    output logic [FRAME_W-1:0] rows_o
);

    // mv_x selects a pixel offset, so the bit offset is mv_x*8; worst case 120+63 = 183.
    always_comb begin
        rows_o = '0;
        for (int r = 0; r < BLK_ROWS; r++) begin
            rows_o[r*ROW_W +: ROW_W] = win_i[5'(mv_y_i) + 5'(r)][{1'b0, mv_x_i, 3'b000} +: ROW_W];
        end
    end

endmodule

// File: rtl/me_blk_feeder.sv
// Loads one current block and its search window, then streams all 256 candidate
// displacements (registered outputs, one per cycle) to the SAD core.
module me_blk_feeder
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [WIN_W-1:0]   ld_data,
    output logic [FRAME_W-1:0] crt_frame,
    output logic [FRAME_W-1:0] pre_frame,
    output logic               crt_keep,
    output logic               cand_valid,
    output mv_t                mv_x,
    output mv_t                mv_y,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    row_t               cur_q [BLK_ROWS];
    win_row_t           win_q [WIN_ROWS];
    logic [FRAME_W-1:0] slice_rows;
    logic [FRAME_W-1:0] crt_frame_q, pre_frame_q;
    mv_t                mv_x_q, mv_y_q;
    logic               crt_keep_q, cand_valid_q;
    logic               gen_cand;

    // In SCAN, cnt runs 0..256: 0..255 generate candidates, 256 drains the output register.
    assign gen_cand = (state_q == ST_SCAN) && !cnt_q[8];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_CUR;
                    cnt_d   = '0;
                end
            end
            ST_LOAD_CUR: begin
                if (ld_valid) begin
                    if (cnt_q == 9'(BLK_ROWS - 1)) begin
                        state_d = ST_LOAD_WIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            ST_LOAD_WIN: begin
                if (ld_valid) begin
                    if (cnt_q == 9'(WIN_ROWS - 1)) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            ST_SCAN: begin
                if (cnt_q == 9'(N_CAND)) begin
                    state_d = ST_FIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the row buffers carry no reset; their contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD_CUR && ld_valid) cur_q[cnt_q[3:0]] <= ld_data[ROW_W-1:0];
        if (state_q == ST_LOAD_WIN && ld_valid) win_q[cnt_q[4:0]] <= ld_data;
    end

    me_win_slice u_win_slice (
        .win_i  (win_q),
        .mv_x_i (cnt_q[3:0]),
        .mv_y_i (cnt_q[7:4]),
        .rows_o (slice_rows)
    );

    // Candidate outputs hold their last values whenever no candidate is generated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crt_frame_q  <= '0;
            pre_frame_q  <= '0;
            mv_x_q       <= '0;
            mv_y_q       <= '0;
            crt_keep_q   <= 1'b1;
            cand_valid_q <= 1'b0;
        end else begin
            cand_valid_q <= gen_cand;
            crt_keep_q   <= !(gen_cand && cnt_q[7:0] == 8'd0);
            if (gen_cand) begin
                mv_x_q      <= cnt_q[3:0];
                mv_y_q      <= cnt_q[7:4];
                pre_frame_q <= slice_rows;
                for (int r = 0; r < BLK_ROWS; r++) begin
                    crt_frame_q[r*ROW_W +: ROW_W] <= cur_q[r];
                end
            end
        end
    end

    assign ld_ready   = (state_q == ST_LOAD_CUR) || (state_q == ST_LOAD_WIN);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign crt_frame  = crt_frame_q;
    assign pre_frame  = pre_frame_q;
    assign crt_keep   = crt_keep_q;
    assign cand_valid = cand_valid_q;
    assign mv_x       = mv_x_q;
    assign mv_y       = mv_y_q;

endmodule

// File: tb/tb_me_blk_feeder.sv
// Scoreboard bench for me_blk_feeder: expected candidates are queued at load time
// and compared as the feeder streams them.
module tb_me_blk_feeder;
    import me_pkg::*;

    logic               clk, rst, start, ld_valid, ld_ready;
    logic [WIN_W-1:0]   ld_data;
    logic [FRAME_W-1:0] crt_frame, pre_frame;
    logic               crt_keep, cand_valid, busy, done;
    mv_t                mv_x, mv_y;

    typedef struct packed {
        mv_t                mx;
        mv_t                my;
        logic               keep;
        logic [FRAME_W-1:0] crt;
        logic [FRAME_W-1:0] pre;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     mon_e;
    int       n_tests = 0;
    int       n_fail  = 0;
    int       cyc     = 0;
    bit       chk_ramp = 0;
    row_t     cur_m [BLK_ROWS];
    win_row_t win_m [WIN_ROWS];

    me_blk_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .crt_frame  (crt_frame),
        .pre_frame  (pre_frame),
        .crt_keep   (crt_keep),
        .cand_valid (cand_valid),
        .mv_x       (mv_x),
        .mv_y       (mv_y),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic win_row_t rand_win();
        win_row_t v;
        for (int p = 0; p < WIN_PIX; p++) v[p*8 +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic fill_pattern(input bit ramp);
        for (int r = 0; r < BLK_ROWS; r++)
            for (int p = 0; p < ROW_PIX; p++)
                cur_m[r][p*8 +: 8] = ramp ? 8'(r*8 + p) : 8'($urandom);
        for (int r = 0; r < WIN_ROWS; r++)
            for (int p = 0; p < WIN_PIX; p++)
                win_m[r][p*8 +: 8] = ramp ? 8'(r + p) : 8'($urandom);
    endtask

    // Expected pre pixel (r,q) of candidate (mx,my) is window pixel (my+r, mx+q).
    task automatic push_expected();
        exp_t e;
        for (int c = 0; c < N_CAND; c++) begin
            e.mx   = 4'(c);
            e.my   = 4'(c >> 4);
            e.keep = (c != 0);
            for (int r = 0; r < BLK_ROWS; r++) begin
                e.crt[r*64 +: 64] = cur_m[r];
                for (int q = 0; q < ROW_PIX; q++)
                    e.pre[r*64 + q*8 +: 8] = win_m[int'(e.my) + r][(int'(e.mx) + q)*8 +: 8];
            end
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst && cand_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_cand", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("mv_x", 64'(mv_x), 64'(mon_e.mx));
                check("mv_y", 64'(mv_y), 64'(mon_e.my));
                check($sformatf("crt_keep c%0d", {mon_e.my, mon_e.mx}), 64'(crt_keep), 64'(mon_e.keep));
                for (int r = 0; r < BLK_ROWS; r++) begin
                    check($sformatf("crt c%0d r%0d", {mon_e.my, mon_e.mx}, r),
                          crt_frame[r*64 +: 64], mon_e.crt[r*64 +: 64]);
                    check($sformatf("pre c%0d r%0d", {mon_e.my, mon_e.mx}, r),
                          pre_frame[r*64 +: 64], mon_e.pre[r*64 +: 64]);
                end
                if (chk_ramp && {mon_e.my, mon_e.mx} == 8'd83) begin
                    check("ramp83_mv_x", 64'(mv_x), 64'd3);
                    check("ramp83_mv_y", 64'(mv_y), 64'd5);
                    check("ramp83_pre_r0p0", 64'(pre_frame[7:0]), 64'd8);
                    check("ramp83_pre_r15p7", 64'(pre_frame[15*64 + 56 +: 8]), 64'd30);
                    check("ramp83_crt_r2p1", 64'(crt_frame[2*64 + 8 +: 8]), 64'd17);
                end
                if (chk_ramp && {mon_e.my, mon_e.mx} == 8'd255)
                    check("corner_pre_r15p7", 64'(pre_frame[15*64 + 56 +: 8]), 64'd52);
            end
        end
    end

    task automatic run_block(input int gap_pct, input bit spurious, input int abort_at);
        int       t0, beat, gaps, guard, n_cand;
        win_row_t d;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        beat  = 0;
        gaps  = 0;
        guard = 0;
        while (beat < BLK_ROWS + WIN_ROWS && guard < 2000) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                ld_valid = 1'b0;
                if (ld_ready) gaps++;
            end else begin
                d = (beat < BLK_ROWS) ? rand_win() : win_m[beat - BLK_ROWS];
                if (beat < BLK_ROWS) d[63:0] = cur_m[beat];
                ld_data  = d;
                ld_valid = 1'b1;
                if (ld_ready) beat++;
            end
        end
        check("load_beats", 64'(beat), 64'(BLK_ROWS + WIN_ROWS));
        @(negedge clk);
        ld_valid = 1'b0;
        guard = 0;
        while (!cand_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cand_valid) begin
            check("first_cand_timeout", 64'd0, 64'd1);
            exp_q.delete();
            return;
        end
        check("first_cand_lat", 64'(cyc - t0), 64'(49 + gaps));
        n_cand = 0;
        guard  = 0;
        while (cand_valid && guard < 1000) begin
            n_cand++;
            if (abort_at >= 0 && n_cand == abort_at + 1) begin
                #1 rst = 1'b0;
                #1;
                check("abort_cand_valid", 64'(cand_valid), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_crt_keep", 64'(crt_keep), 64'd1);
                check("abort_mv", 64'({mv_y, mv_x}), 64'd0);
                @(negedge clk);
                rst = 1'b1;
                exp_q.delete();
                return;
            end
            if (spurious && n_cand >= 10 && n_cand < 40) begin
                start    = 1'($urandom);
                ld_valid = 1'b1;
                ld_data  = rand_win();
            end else begin
                start    = 1'b0;
                ld_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        check("cand_count", 64'(n_cand), 64'(N_CAND));
        check("done_lat", 64'(cyc - t0), 64'(305 + gaps));
        check("done_pulse", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("hold_valid", 64'(cand_valid), 64'd0);
        check("hold_mv", 64'({mv_y, mv_x}), 64'hFF);
        check("hold_pre_r0", pre_frame[63:0], win_m[15][15*8 +: 64]);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        rst   = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        check("rst_cand_valid", 64'(cand_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_crt_keep", 64'(crt_keep), 64'd1);
        check("rst_mv", 64'({mv_y, mv_x}), 64'd0);
        check("rst_crt_zero", 64'(|crt_frame), 64'd0);
        check("rst_pre_zero", 64'(|pre_frame), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ld_ready", 64'(ld_ready), 64'd0);

        fill_pattern(1'b1);
        chk_ramp = 1'b1;
        run_block(0, 1'b0, -1);
        chk_ramp = 1'b0;
        run_block(30, 1'b0, -1);
        fill_pattern(1'b0);
        run_block(0, 1'b1, -1);
        fill_pattern(1'b0);
        run_block(20, 1'b0, 100);
        fill_pattern(1'b0);
        run_block(0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/me_blk_feeder.md
Name: me_blk_feeder

Overview:
- Producer side of the motion-estimation core's frame interface.
- Buffers one 16x8 current block and its 31x23 search window, loaded as row beats from the frame-store reader.
- Then streams all 256 candidate displacements to the SAD core, one per cycle.
- For each candidate it presents the 16 current rows, the 16 displaced previous-frame rows, crt_keep, and the candidate's motion vector.

Parameters:
- BLK_ROWS, 16, rows per block (fixed by the core).
- ROW_PIX, 8, pixels per row (64-bit row).
- PIX_W, 8, bits per pixel.
- RANGE, 16, search positions per axis; mv_x/mv_y are 4 bits.
- WIN_ROWS, BLK_ROWS+RANGE-1 = 31, search-window rows.
- WIN_PIX, ROW_PIX+RANGE-1 = 23, search-window pixels per row (184 bits).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  pulse; begin loading a new block (honoured in IDLE only)
- ld_valid  in  1  load beat valid
- ld_ready  out  1  feeder accepts beat
- ld_data  in  184  load row; current-block beats use [63:0], window beats use all bits; pixel p at [8p+7:8p]
- crt_frame  out  1024  16 current rows flattened; row i at [64i+63:64i]
- pre_frame  out  1024  16 displaced window rows, same packing
- crt_keep  out  1  0 = core captures crt rows this cycle; 1 = hold
- cand_valid  out  1  candidate on outputs is valid
- mv_x  out  4  candidate horizontal offset
- mv_y  out  4  candidate vertical offset
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last candidate

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low; asserting it clears all state.
- Reset values: state=IDLE; all counters 0; ld_ready, cand_valid, busy and done 0; crt_keep 1; mv_x, mv_y, crt_frame and pre_frame 0. Buffer contents after reset are don't-care.
- Asserting rst mid-load or mid-scan aborts the operation. There is no partial resume.
- FSM: IDLE -> LOAD_CUR -> LOAD_WIN -> SCAN -> FIN -> IDLE.
- IDLE: start=1 moves to LOAD_CUR next cycle. A start in any other state is ignored.
- LOAD_CUR:
  - ld_ready=1; a beat transfers when ld_valid&&ld_ready.
  - Beat k (0..15) writes cur_row[k] from ld_data[63:0]; ld_data[183:64] is ignored.
  - The 16th transfer moves to LOAD_WIN and resets the row counter.
- LOAD_WIN: ld_ready=1; beat k (0..30) writes win_row[k]. The 31st transfer moves to SCAN.
- ld_valid is ignored outside the load states, where ld_ready=0. Gaps in ld_valid simply stall the load.
- SCAN:
  - 8-bit candidate counter c runs 0..255, one per cycle, with no backpressure; mv_x=c[3:0], mv_y=c[7:4].
  - Outputs are registered, so the candidate for counter value c appears on the cycle after c is generated.
  - cand_valid is high for exactly 256 consecutive cycles.
  - For each displayed candidate: pre row r = win_row[mv_y+r][8*mv_x +: 64] and crt row r = cur_row[r].
  - crt_keep=0 only with the first candidate (mv 0,0) and 1 for the other 255.
  - Extreme candidate (15,15) reads window row 30, pixels 15..22; no index may exceed the buffer.
- FIN: done=1 for one cycle, coinciding with the cycle after the last cand_valid, then IDLE. busy drops in IDLE.
- Hold behaviour: outside SCAN output, cand_valid=0 and crt_frame, pre_frame and mv hold their last values.
- Capacity: a new start is accepted the cycle after returning to IDLE. Total latency start -> done = 1 + 16 + 31 + 256 + 1 cycles with no load gaps.

Decomposition:
- Shared package me_pkg:
  - Constants BLK_ROWS, ROW_PIX, PIX_W, RANGE, WIN_ROWS, WIN_PIX.
  - Row/word typedefs: row_t [63:0], win_row_t [183:0], mv_t [3:0].
  - FSM state enum.
- One natural sub-module: me_win_slice, a combinational 16-row window extractor (win buffer, mv_x, mv_y -> 16x64 rows). The top registers its output.

Test Plan:
- Reset and idle: assert rst low mid-idle with start held -> all outputs at reset values; ld_ready=0. After release, no activity until a start pulse.
- Ramp block, candidate (3,5): load cur pixel=(r*8+p); window pixel=(r+p) mod 256; start.
  - 256 cand_valid cycles; cycle index 83 shows mv_x=3, mv_y=5.
  - pre row 0 pixel 0 = 8; row 15 pixel 7 = 30.
  - crt row 2 pixel 1 = 17.
  - crt_keep=0 only at index 0.
- Corner (15,15), same pattern: last candidate pre row 15 pixel 7 = 30+22 = 52. done pulses exactly one cycle later; busy falls the next cycle.
- Load gaps: randomly deasserted ld_valid during both load phases -> buffered data identical to the gapless run; first cand_valid delayed by exactly the gap count.
- Spurious inputs: start pulses and ld_valid beats during SCAN -> ignored; no FSM restart, buffers unchanged, candidate sequence identical.
- Mid-scan reset: rst low at candidate 100 -> cand_valid=0 immediately (asynchronous clear). A following full load+scan produces correct values.
